// File: rtl/r5p_bus_arb.sv
// Two-requester arbiter sharing one memory port between instruction fetch (read-only) and load/store.
// Grant is combinational; an owner that is stalled on mem_rdy is locked in. Read data returns one cycle after completion.
module r5p_bus_arb #(
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned BW   = DW/8,
    parameter bit          FAIR = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_vld,
    input  logic [AW-1:0] if_adr,
    output logic [DW-1:0] if_rdt,
    output logic          if_rdy,
    input  logic          ls_vld,
    input  logic          ls_wen,
    input  logic [AW-1:0] ls_adr,
    input  logic [BW-1:0] ls_ben,
    input  logic [DW-1:0] ls_wdt,
    output logic [DW-1:0] ls_rdt,
    output logic          ls_rdy,
    output logic          mem_vld,
    output logic          mem_wen,
    output logic [AW-1:0] mem_adr,
    output logic [BW-1:0] mem_ben,
    output logic [DW-1:0] mem_wdt,
    input  logic [DW-1:0] mem_rdt,
    input  logic          mem_rdy
);

    typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} own_t;

    logic          lock_q, lock_d;
    own_t          own_q, own_d;
    own_t          lst_q, lst_d;
    logic          rsp_if_q, rsp_if_d;
    logic          rsp_ls_q, rsp_ls_d;
    logic [DW-1:0] if_hld_q, if_hld_d;
    logic [DW-1:0] ls_hld_q, ls_hld_d;
    own_t          gnt;
    logic          done;

    always_comb begin
        if (lock_q) begin
            gnt = own_q;
        end else if (if_vld && ls_vld) begin
            if (FAIR) begin
                gnt = (lst_q == OWN_IF) ? OWN_LS : OWN_IF;
            end else begin
                gnt = OWN_LS;
            end
        end else if (ls_vld) begin
            gnt = OWN_LS;
        end else begin
            gnt = OWN_IF;
        end
    end

    always_comb begin
        mem_vld = 1'b0;
        mem_wen = 1'b0;
        mem_adr = '0;
        mem_ben = '0;
        mem_wdt = '0;
        if (gnt == OWN_LS) begin
            if (ls_vld) begin
                mem_vld = 1'b1;
                mem_wen = ls_wen;
                mem_adr = ls_adr;
                mem_ben = ls_ben;
                mem_wdt = ls_wdt;
            end
        end else if (if_vld) begin
            mem_vld = 1'b1;
            mem_adr = if_adr;
            mem_ben = '1;
        end
    end

    assign if_rdy = (gnt == OWN_IF) && if_vld && mem_rdy;
    assign ls_rdy = (gnt == OWN_LS) && ls_vld && mem_rdy;
    assign done   = mem_vld && mem_rdy;

    // Response owner is registered so read data lands on the right requester one cycle later.
    always_comb begin
        lock_d   = mem_vld && !mem_rdy;
        own_d    = gnt;
        lst_d    = done ? gnt : lst_q;
        rsp_if_d = done && (gnt == OWN_IF);
        rsp_ls_d = done && (gnt == OWN_LS) && !mem_wen;
        if_hld_d = rsp_if_q ? mem_rdt : if_hld_q;
        ls_hld_d = rsp_ls_q ? mem_rdt : ls_hld_q;
    end

    assign if_rdt = rsp_if_q ? mem_rdt : if_hld_q;
    assign ls_rdt = rsp_ls_q ? mem_rdt : ls_hld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q   <= 1'b0;
            own_q    <= OWN_IF;
            lst_q    <= OWN_IF;
            rsp_if_q <= 1'b0;
            rsp_ls_q <= 1'b0;
            if_hld_q <= '0;
            ls_hld_q <= '0;
        end else begin
            lock_q   <= lock_d;
            own_q    <= own_d;
            lst_q    <= lst_d;
            rsp_if_q <= rsp_if_d;
            rsp_ls_q <= rsp_ls_d;
            if_hld_q <= if_hld_d;
            ls_hld_q <= ls_hld_d;
        end
    end

endmodule
